// File: rtl/id_ex_pkg.sv
// Shared widths, RV32I opcode/funct constants and the ID/EX stage bundles.
// Optional build macro consumed by this slice: RF_WRITE_BYPASS_EN.
package id_ex_pkg;

  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int WORD_W     = 32;
  localparam int REG_IDX_W  = 5;
  localparam int ALU_OP_W   = 4;
  localparam int MEM_OP_W   = 4;
  localparam int DEST_SRC_W = 2;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int F7_ALT_BIT = 30;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU,
    MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_NONE, DEST_ALU, DEST_MEM
  } dest_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [INSTR_W-1:0]   instr;
    alu_op_e              alu_op;
    logic [WORD_W-1:0]    a;
    logic [WORD_W-1:0]    b;
    mem_op_e              mem_op;
    logic [WORD_W-1:0]    mem_data;
    dest_src_e            dest_src;
    logic [REG_IDX_W-1:0] dest_reg;
  } id_ex_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [INSTR_W-1:0]   instr;
    logic [WORD_W-1:0]    alu_eval;
    mem_op_e              mem_op;
    logic [WORD_W-1:0]    mem_data;
    dest_src_e            dest_src;
    logic [REG_IDX_W-1:0] dest_reg;
  } ex_mem_t;

  localparam id_ex_t ID_BUBBLE = '{
    pc: '0, instr: NOP_INSTR, alu_op: ALU_ADD, a: '0, b: '0,
    mem_op: MEM_NONE, mem_data: '0, dest_src: DEST_NONE, dest_reg: '0
  };

  localparam ex_mem_t EX_BUBBLE = '{
    pc: '0, instr: NOP_INSTR, alu_eval: '0, mem_op: MEM_NONE,
    mem_data: '0, dest_src: DEST_NONE, dest_reg: '0
  };

  // alt is funct7[5]; only register-register ops may turn ADD into SUB
  function automatic alu_op_e alu_decode(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_op
  );
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ex_reg_file.sv
// 32x32 register file: two async read ports, one write port, x0 hardwired.
// RF_WRITE_BYPASS_EN forwards a same-cycle write to the read ports.
module id_ex_reg_file
  import id_ex_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic [REG_IDX_W-1:0] raddr1_i,
  input  logic [REG_IDX_W-1:0] raddr2_i,
  output logic [WORD_W-1:0]    rdata1_o,
  output logic [WORD_W-1:0]    rdata2_o
);

  logic [WORD_W-1:0] regs_q [32];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  assign rdata1_o = (raddr1_i == '0) ? '0 :
                    (wr_en && waddr_i == raddr1_i) ? wdata_i :
                    regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 :
                    (wr_en && waddr_i == raddr2_i) ? wdata_i :
                    regs_q[raddr2_i];
`else
  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`endif

endmodule

// File: rtl/id_ex.sv
// RV32I decode + execute stages with per-stage clear/stall.
// Build option: RF_WRITE_BYPASS_EN (same-cycle writeback forwarding in RF).
module id_ex
  import id_ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_clr,
  input  logic                  id_stall,
  input  logic                  ex_clr,
  input  logic                  ex_stall,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic                  i_wb_dest_en,
  input  logic [REG_IDX_W-1:0]  i_wb_dest_reg,
  input  logic [WORD_W-1:0]     i_wb_dest_data,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [WORD_W-1:0]     o_alu_eval,
  output logic [MEM_OP_W-1:0]   o_mem_op,
  output logic [WORD_W-1:0]     o_mem_data,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg
);

  id_ex_t  id_d, id_q;
  ex_mem_t ex_d, ex_q;

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [WORD_W-1:0] rs1_v, rs2_v;
  logic [WORD_W-1:0] imm_i, imm_s, imm_u;

  assign opc   = i_instr[6:0];
  assign f3    = i_instr[14:12];
  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_u = {i_instr[31:12], 12'b0};

  id_ex_reg_file u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (i_wb_dest_en),
    .waddr_i  (i_wb_dest_reg),
    .wdata_i  (i_wb_dest_data),
    .raddr1_i (i_instr[19:15]),
    .raddr2_i (i_instr[24:20]),
    .rdata1_o (rs1_v),
    .rdata2_o (rs2_v)
  );

  logic              valid;
  alu_op_e           dec_op;
  logic [WORD_W-1:0] dec_a, dec_b, dec_md;
  mem_op_e           dec_mem;
  dest_src_e         dec_dst;

  always_comb begin
    valid   = 1'b1;
    dec_op  = ALU_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_md  = '0;
    dec_mem = MEM_NONE;
    dec_dst = DEST_ALU;
    unique case (1'b1)
      (opc == OPC_OP_IMM): begin
        dec_op = alu_decode(f3, i_instr[F7_ALT_BIT], 1'b0);
        dec_a  = rs1_v;
        dec_b  = (f3 == F3_SLL || f3 == F3_SR) ?
                 {27'b0, i_instr[24:20]} : imm_i;
      end
      (opc == OPC_OP): begin
        dec_op = alu_decode(f3, i_instr[F7_ALT_BIT], 1'b1);
        dec_a  = rs1_v;
        dec_b  = rs2_v;
      end
      (opc == OPC_LUI): dec_b = imm_u;
      (opc == OPC_AUIPC): begin
        dec_a = i_pc;
        dec_b = imm_u;
      end
      (opc == OPC_LOAD): begin
        dec_a   = rs1_v;
        dec_b   = imm_i;
        dec_dst = DEST_MEM;
        case (f3)
          F3_B:    dec_mem = MEM_LB;
          F3_H:    dec_mem = MEM_LH;
          F3_W:    dec_mem = MEM_LW;
          F3_BU:   dec_mem = MEM_LBU;
          F3_HU:   dec_mem = MEM_LHU;
          default: valid   = 1'b0;
        endcase
      end
      (opc == OPC_STORE): begin
        dec_a   = rs1_v;
        dec_b   = imm_s;
        dec_md  = rs2_v;
        dec_dst = DEST_NONE;
        case (f3)
          F3_B:    dec_mem = MEM_SB;
          F3_H:    dec_mem = MEM_SH;
          F3_W:    dec_mem = MEM_SW;
          default: valid   = 1'b0;
        endcase
      end
      default: valid = 1'b0;
    endcase

    id_d = ID_BUBBLE;
    if (valid) begin
      id_d = '{
        pc: i_pc, instr: i_instr, alu_op: dec_op, a: dec_a, b: dec_b,
        mem_op: dec_mem, mem_data: dec_md, dest_src: dec_dst,
        dest_reg: (dec_dst == DEST_NONE) ? '0 : i_instr[11:7]
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         id_q <= ID_BUBBLE;
    else if (id_clr)    id_q <= ID_BUBBLE;
    else if (!id_stall) id_q <= id_d;
  end

  logic [WORD_W-1:0] alu_res;
  logic [4:0]        sh;

  assign sh = id_q.b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (id_q.alu_op)
      ALU_ADD:  alu_res = id_q.a + id_q.b;
      ALU_SUB:  alu_res = id_q.a - id_q.b;
      ALU_SLL:  alu_res = id_q.a << sh;
      ALU_SLT:  alu_res = {31'b0, $signed(id_q.a) < $signed(id_q.b)};
      ALU_SLTU: alu_res = {31'b0, id_q.a < id_q.b};
      ALU_XOR:  alu_res = id_q.a ^ id_q.b;
      ALU_SRL:  alu_res = id_q.a >> sh;
      ALU_SRA:  alu_res = $unsigned($signed(id_q.a) >>> sh);
      ALU_OR:   alu_res = id_q.a | id_q.b;
      ALU_AND:  alu_res = id_q.a & id_q.b;
      default:  alu_res = '0;
    endcase
    ex_d = '{
      pc: id_q.pc, instr: id_q.instr, alu_eval: alu_res,
      mem_op: id_q.mem_op, mem_data: id_q.mem_data,
      dest_src: id_q.dest_src, dest_reg: id_q.dest_reg
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ex_q <= EX_BUBBLE;
    else if (ex_clr)    ex_q <= EX_BUBBLE;
    else if (!ex_stall) ex_q <= ex_d;
  end

  assign o_pc       = ex_q.pc;
  assign o_instr    = ex_q.instr;
  assign o_alu_eval = ex_q.alu_eval;
  assign o_mem_op   = ex_q.mem_op;
  assign o_mem_data = ex_q.mem_data;
  assign o_dest_src = ex_q.dest_src;
  assign o_dest_reg = ex_q.dest_reg;

endmodule

// File: tb/tb_id_ex.sv
// Directed-vector bench for id_ex: table of single instructions plus
// hand-written clear/stall/bypass/reset sequences.
module tb_id_ex;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_clr = 1'b0, id_stall = 1'b0;
  logic        ex_clr = 1'b0, ex_stall = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_instr = 32'h13;
  logic        i_wb_dest_en = 1'b0;
  logic [4:0]  i_wb_dest_reg = '0;
  logic [31:0] i_wb_dest_data = '0;
  logic [31:0] o_pc, o_instr, o_alu_eval, o_mem_data;
  logic [3:0]  o_mem_op;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_clr         (id_clr),
    .id_stall       (id_stall),
    .ex_clr         (ex_clr),
    .ex_stall       (ex_stall),
    .i_pc           (i_pc),
    .i_instr        (i_instr),
    .i_wb_dest_en   (i_wb_dest_en),
    .i_wb_dest_reg  (i_wb_dest_reg),
    .i_wb_dest_data (i_wb_dest_data),
    .o_pc           (o_pc),
    .o_instr        (o_instr),
    .o_alu_eval     (o_alu_eval),
    .o_mem_op       (o_mem_op),
    .o_mem_data     (o_mem_data),
    .o_dest_src     (o_dest_src),
    .o_dest_reg     (o_dest_reg)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [3:0]  mop;
    logic [1:0]  dsrc;
    logic [4:0]  dreg;
    logic [31:0] mdata;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vecs [12];

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    i_wb_dest_en   = 1'b1;
    i_wb_dest_reg  = r;
    i_wb_dest_data = d;
    tick();
    i_wb_dest_en   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
    i_pc    = pc;
    i_instr = ins;
    tick();
    i_pc    = '0;
    i_instr = NOP;
    tick();
  endtask

  logic [31:0] byp_exp;

  initial begin
    vecs[0]  = '{"addi",  32'h10,  32'hFFF00093, 32'hFFFFFFFF, 4'd0, 2'd1, 5'd1,  32'd0, 32'h10,  32'hFFF00093};
    vecs[1]  = '{"add",   32'h14,  32'h002101B3, 32'd10,       4'd0, 2'd1, 5'd3,  32'd0, 32'h14,  32'h002101B3};
    vecs[2]  = '{"sub",   32'h18,  32'h406102B3, 32'hFFFFFFFE, 4'd0, 2'd1, 5'd5,  32'd0, 32'h18,  32'h406102B3};
    vecs[3]  = '{"srai",  32'h1C,  32'h4043D293, 32'hF8000000, 4'd0, 2'd1, 5'd5,  32'd0, 32'h1C,  32'h4043D293};
    vecs[4]  = '{"sltu",  32'h20,  32'h009432B3, 32'd1,        4'd0, 2'd1, 5'd5,  32'd0, 32'h20,  32'h009432B3};
    vecs[5]  = '{"slt",   32'h24,  32'h0084A2B3, 32'd1,        4'd0, 2'd1, 5'd5,  32'd0, 32'h24,  32'h0084A2B3};
    vecs[6]  = '{"lui",   32'h28,  32'h12345537, 32'h12345000, 4'd0, 2'd1, 5'd10, 32'd0, 32'h28,  32'h12345537};
    vecs[7]  = '{"auipc", 32'h100, 32'h00001597, 32'h00001100, 4'd0, 2'd1, 5'd11, 32'd0, 32'h100, 32'h00001597};
    vecs[8]  = '{"lw",    32'h2C,  32'h0080A203, 32'h28,       4'd3, 2'd2, 5'd4,  32'd0, 32'h2C,  32'h0080A203};
    vecs[9]  = '{"sw",    32'h30,  32'h00202223, 32'd4,        4'd8, 2'd0, 5'd0,  32'd5, 32'h30,  32'h00202223};
    vecs[10] = '{"jal",   32'h34,  32'h008000EF, 32'd0,        4'd0, 2'd0, 5'd0,  32'd0, 32'h0,   NOP};
    vecs[11] = '{"x0",    32'h38,  32'h000002B3, 32'd0,        4'd0, 2'd1, 5'd5,  32'd0, 32'h38,  32'h000002B3};

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_alu",   o_alu_eval, 32'd0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc",    o_pc, 32'd0);
    chk("rst_dsrc",  32'(o_dest_src), 32'd0);
    chk("rst_mop",   32'(o_mem_op), 32'd0);
    rst_n = 1'b1;
    tick();

    wb(5'd2, 32'd5);
    wb(5'd6, 32'd7);
    wb(5'd7, 32'h80000000);
    wb(5'd8, 32'd1);
    wb(5'd9, 32'hFFFFFFFF);
    wb(5'd1, 32'h20);
    wb(5'd0, 32'h55);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].pc, vecs[i].instr);
      chk({vecs[i].name, "_alu"},   o_alu_eval, vecs[i].alu);
      chk({vecs[i].name, "_mop"},   32'(o_mem_op), 32'(vecs[i].mop));
      chk({vecs[i].name, "_dsrc"},  32'(o_dest_src), 32'(vecs[i].dsrc));
      chk({vecs[i].name, "_dreg"},  32'(o_dest_reg), 32'(vecs[i].dreg));
      chk({vecs[i].name, "_mdata"}, o_mem_data, vecs[i].mdata);
      chk({vecs[i].name, "_pc"},    o_pc, vecs[i].epc);
      chk({vecs[i].name, "_instr"}, o_instr, vecs[i].einstr);
    end

    // id_clr during the second of three back-to-back addis
    i_instr = 32'h00100293;
    tick();
    i_instr = 32'h00200293;
    id_clr  = 1'b1;
    tick();
    chk("clr_first", o_alu_eval, 32'd1);
    i_instr = 32'h00300293;
    id_clr  = 1'b0;
    tick();
    chk("clr_bub_alu",  o_alu_eval, 32'd0);
    chk("clr_bub_dsrc", 32'(o_dest_src), 32'd0);
    chk("clr_bub_ins",  o_instr, NOP);
    i_instr = NOP;
    tick();
    chk("clr_third", o_alu_eval, 32'd3);

    // stall both stages: EX output must hold
    i_pc = 32'h40; i_instr = 32'h00100293;
    tick();
    i_pc = 32'h44; i_instr = 32'h00200293;
    tick();
    chk("stl_pc0", o_pc, 32'h40);
    i_pc = 32'h48; i_instr = 32'h00300293;
    id_stall = 1'b1; ex_stall = 1'b1;
    tick();
    chk("stl_hold_pc",  o_pc, 32'h40);
    chk("stl_hold_ins", o_instr, 32'h00100293);
    id_stall = 1'b0; ex_stall = 1'b0;
    tick();
    chk("stl_next_pc", o_pc, 32'h44);
    tick();
    chk("stl_last_pc", o_pc, 32'h48);

    // clr and stall together: clr wins
    i_pc = 32'h80; i_instr = 32'h00900293;
    tick();
    id_clr = 1'b1; id_stall = 1'b1;
    tick();
    id_clr = 1'b0; id_stall = 1'b0;
    i_pc = '0; i_instr = NOP;
    tick();
    chk("cs_dsrc", 32'(o_dest_src), 32'd0);
    chk("cs_pc",   o_pc, 32'd0);
    chk("cs_alu",  o_alu_eval, 32'd0);

    // same-cycle writeback and read of x12
`ifdef RF_WRITE_BYPASS_EN
    byp_exp = 32'h77;
`else
    byp_exp = 32'h0;
`endif
    i_wb_dest_en = 1'b1; i_wb_dest_reg = 5'd12; i_wb_dest_data = 32'h77;
    i_instr = 32'h000606B3;
    tick();
    i_wb_dest_en = 1'b0;
    i_instr = NOP;
    tick();
    chk("byp_same", o_alu_eval, byp_exp);
    issue(32'h0, 32'h000606B3);
    chk("byp_next", o_alu_eval, 32'h77);

    // async reset mid-flight flushes stages and register file
    issue(32'h60, 32'h00700293);
    chk("pre_rst", o_alu_eval, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu",  o_alu_eval, 32'd0);
    chk("arst_dsrc", 32'(o_dest_src), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(32'h0, 32'h000606B3);
    chk("arst_rf", o_alu_eval, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
